axi_lite_sram_bridge: RTL
=========================

Name: axi_lite_sram_bridge

Overview:
- AXI4-Lite slave that converts read/write transactions into single-cycle requests on the DPI-backed SRAM request port (req/wr/addr/wdata/wmask in, rdata out).
- Sits between the core's LSU/IFU AXI-Lite master (or crossbar) and the SRAM model.
- Handles one outstanding transaction at a time.
- Arbitrates between reads and writes, range-checks addresses, and returns AXI responses.

Parameters:
- ADDR_W, 32, AXI and SRAM address width.
- DATA_W, 32, data width; only 32 is supported.
- BASE_ADDR, 32'h8000_0000, first valid byte address.
- SIZE_BYTES, 32'h0800_0000, size of the valid window; addr outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES) gets SLVERR.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_W  read data
- rresp  out  2  read response: 00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_W  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- sram_req  out  1  SRAM request strobe, one cycle per access
- sram_wr  out  1  1 = write, 0 = read
- sram_addr  out  32  byte address, passed through unaligned bits unchanged
- sram_wdata  out  32  write data
- sram_wmask  out  8  {4'b0, wstrb}
- sram_rdata  in  32  read data, valid on the cycle after a read req

Behaviour:
- Reset (async on reset_n low):
  - state = IDLE.
  - All valid/ready/req outputs 0; rdata, rresp, bresp, sram_addr, sram_wdata, sram_wmask = 0.
  - Priority flag prio_wr = 0.
- States: IDLE, RD_WAIT, RD_RESP, WR_RESP.
- IDLE:
  - arready = 1 when a read is selected.
  - awready = wready = 1 together, and only when awvalid && wvalid are both high and a write is selected. AW without W, or W without AW, waits with no handshake.
- Arbitration when a read and a complete write are pending in the same cycle:
  - prio_wr = 0 selects the read; prio_wr = 1 selects the write.
  - prio_wr toggles after every granted transaction, so reads and writes round-robin.
  - A lone request is granted immediately.
- Read grant (arvalid && arready):
  - In-range: sram_req = 1, sram_wr = 0, sram_addr = araddr in the same cycle (combinational from the handshake); next state RD_WAIT.
  - Out-of-range: no sram_req; rresp = SLVERR, rdata = 0; next state RD_RESP.
- RD_WAIT: capture sram_rdata into rdata, rresp = OKAY; next state RD_RESP. Read latency from AR handshake to rvalid is 2 cycles.
- RD_RESP: rvalid = 1; rdata and rresp held stable until rready. On rvalid && rready go to IDLE; a new AR can be accepted the following cycle.
- Write grant:
  - In-range and wstrb != 0: sram_req = 1, sram_wr = 1, sram_addr = awaddr, sram_wdata = wdata, sram_wmask = {4'b0, wstrb} in the grant cycle; bresp = OKAY.
  - wstrb == 0: no sram_req; bresp = OKAY.
  - Out-of-range: no sram_req; bresp = SLVERR.
  - Next state WR_RESP.
- WR_RESP: bvalid = 1 until bready, then IDLE. Write latency from AW/W handshake to bvalid is 1 cycle.
- No SRAM request is issued outside a grant cycle: at most one sram_req per AXI transaction, never while a response is pending.
- Range check:
  - Unsigned compare addr >= BASE_ADDR && (addr - BASE_ADDR) < SIZE_BYTES.
  - Computed in ADDR_W+1 bits so the top-of-space window does not wrap.
- Response channels: rvalid and bvalid never drop without the matching ready; payloads stay constant while valid is high.
- Reset mid-transaction returns to IDLE immediately. Any pending response is discarded; an SRAM request already issued is not retracted.
- rready/bready asserted early (before valid) is legal and ignored until valid.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - State enum type.
  - Range-check function in_range(addr, base, size).
- One sub-module is natural: axi_lite_sram_arb, the IDLE-state read/write arbiter with the prio_wr flag, outputting grant_rd/grant_wr.
- The FSM and datapath stay in the top module.

Test Plan:
- Write then read: AW/W addr 0x8000_0010, wdata 0xDEADBEEF, wstrb 4'hF.
  - Expect sram_req with wr = 1 and wmask 8'h0F; bvalid 1 cycle later with bresp 00.
  - AR at the same address: sram_req with wr = 0, rvalid 2 cycles after the handshake, rdata 0xDEADBEEF, rresp 00.
- Partial strobe: wstrb 4'b0010 to 0x8000_0020 -> sram_wmask 8'h02. wstrb 0 -> bvalid with OKAY and no sram_req.
- Out-of-range: AR at 0x0000_1000 -> no sram_req, rresp 10, rdata 0. AW at 0x8800_0000 -> bresp 10, no sram_req.
- Simultaneous AR and AW/W for 4 back-to-back rounds -> grants alternate R, W, R, W. AW without W for 5 cycles -> awready stays 0.
- Backpressure: hold rready = 0 for 6 cycles -> rvalid, rdata, rresp stable; no new arready, no sram_req.
- Reset: assert reset_n = 0 in RD_RESP -> rvalid = 0 asynchronously, state IDLE after release, next read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared response codes, bridge FSM state type and address
//               window check for the AXI-Lite to SRAM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2,
        WR_RESP = 2'd3
    } state_t;

    // One extra bit keeps a window ending at the top of the address space from wrapping.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
        logic [32:0] w_off;
        w_off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (w_off < {1'b0, size});
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_sram_arb.sv
// ============================================================================
// Module      : axi_lite_sram_arb
// Description : Round-robin read/write grant for the idle bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_sram_arb (
    input  logic clock,
    input  logic reset_n,
    input  logic idle,
    input  logic rd_req,
    input  logic wr_req,
    output logic grant_rd,
    output logic grant_wr
);

    logic r_prio_wr;

    // Priority only matters on a collision; a lone request always wins.
    assign grant_rd = idle && rd_req && (!wr_req || !r_prio_wr);
    assign grant_wr = idle && wr_req && (!rd_req ||  r_prio_wr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prio_wr <= 1'b0;
        end else if (grant_rd || grant_wr) begin
            r_prio_wr <= ~r_prio_wr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_lite_sram_bridge.sv
// ============================================================================
// Module      : axi_lite_sram_bridge
// Description : AXI4-Lite slave turning single transactions into one-cycle
//               SRAM requests, with address window check and round-robin R/W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_sram_bridge
    import axi_lite_pkg::*;
#(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h8000_0000,
    parameter logic [ADDR_W-1:0]  SIZE_BYTES = 32'h0800_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              sram_req,
    output logic              sram_wr,
    output logic [31:0]       sram_addr,
    output logic [31:0]       sram_wdata,
    output logic [7:0]        sram_wmask,
    input  logic [31:0]       sram_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [1:0]        r_bresp;
    logic              w_grant_rd;
    logic              w_grant_wr;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_wr_hit;

    axi_lite_sram_arb u_arb (
        .clock    (clock),
        .reset_n  (reset_n),
        .idle     (r_state == IDLE),
        .rd_req   (arvalid),
        .wr_req   (awvalid && wvalid),
        .grant_rd (w_grant_rd),
        .grant_wr (w_grant_wr)
    );

    assign w_rd_ok  = in_range(araddr, BASE_ADDR, SIZE_BYTES);
    assign w_wr_ok  = in_range(awaddr, BASE_ADDR, SIZE_BYTES);
    assign w_wr_hit = w_wr_ok && (wstrb != 4'b0000);

    assign arready = w_grant_rd;
    assign awready = w_grant_wr;
    assign wready  = w_grant_wr;
    assign rvalid  = (r_state == RD_RESP);
    assign bvalid  = (r_state == WR_RESP);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign bresp   = r_bresp;

    // The SRAM port is only driven during the grant cycle itself.
    always_comb begin
        sram_req   = 1'b0;
        sram_wr    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wmask = '0;
        if (w_grant_rd && w_rd_ok) begin
            sram_req  = 1'b1;
            sram_addr = araddr;
        end else if (w_grant_wr && w_wr_hit) begin
            sram_req   = 1'b1;
            sram_wr    = 1'b1;
            sram_addr  = awaddr;
            sram_wdata = wdata;
            sram_wmask = {4'b0000, wstrb};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_rd) begin
                    w_state_nxt = w_rd_ok ? RD_WAIT : RD_RESP;
                end else if (w_grant_wr) begin
                    w_state_nxt = WR_RESP;
                end
            end
            RD_WAIT: w_state_nxt = RD_RESP;
            RD_RESP: if (rready) w_state_nxt = IDLE;
            WR_RESP: if (bready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_grant_rd) begin
                r_rdata <= '0;
                r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_state == RD_WAIT) begin
                r_rdata <= sram_rdata;
                r_rresp <= RESP_OKAY;
            end
            if (w_grant_wr) begin
                r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

`default_nettype wire
